ground_scheduler: RTL

Time-multiplexed controller for the game's moving ground platforms. It owns the fixed-point position and direction of NUM_GROUNDS vertically moving grounds and sweeps them once per frame through a single shared step/bounce datapath. Speed is scaled per level, and pause and per-ground enables are honoured. It sits between the frame timing generator and the ground draw/collision logic, and replaces one free-running mover per platform.

---
 rtl/ground_pkg.sv | 25 ++
 rtl/ground_scheduler_if.sv | 26 ++
 rtl/ground_step.sv | 30 +++
 rtl/ground_scheduler.sv | 105 ++++++++++
 4 files changed

// File: rtl/ground_pkg.sv
// Shared types and constants for the moving-ground scheduler: fixed-point format,
// sweep FSM states and the per-ground position/direction record.
package ground_pkg;

  localparam int FP_SHIFT = 6;
  localparam int POS_W    = 18;
  localparam int COORD_W  = 11;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  // dir: 0 moves down (+), 1 moves up (-)
  typedef struct packed {
    logic signed [POS_W-1:0] pos;
    logic                    dir;
  } ground_t;

  function automatic logic signed [POS_W-1:0] level_speed(input int base, input logic [1:0] level);
    return POS_W'(base * (int'(level) + 1));
  endfunction

endpackage

// File: rtl/ground_scheduler_if.sv
// Frame-side controls and per-ground coordinate outputs of the ground scheduler.
interface ground_scheduler_if #(
  parameter int NUM_GROUNDS = 4
);

  logic                            startOfFrame;
  logic                            pause;
  logic [1:0]                      level;
  logic [NUM_GROUNDS-1:0]          groundEnable;
  logic signed [NUM_GROUNDS*11-1:0] topLeftX;
  logic signed [NUM_GROUNDS*11-1:0] topLeftY;
  logic                            busy;
  logic                            frameDone;
  logic                            overrun;

  modport master (
    output startOfFrame, pause, level, groundEnable,
    input  topLeftX, topLeftY, busy, frameDone, overrun
  );

  modport slave (
    input  startOfFrame, pause, level, groundEnable,
    output topLeftX, topLeftY, busy, frameDone, overrun
  );

endinterface

// File: rtl/ground_step.sv
// Shared step/bounce datapath: advances one ground by speed and reflects it at
// the top and bottom limits, clamping onto the limit on the bounce frame.
module ground_step
  import ground_pkg::*;
#(
  parameter int MIN_P = 90,
  parameter int MAX_P = 385
) (
  input  ground_t                 cur,
  input  logic signed [POS_W-1:0] speed,
  output ground_t                 nxt
);

  localparam logic signed [POS_W-1:0] MIN_FP = POS_W'(MIN_P << FP_SHIFT);
  localparam logic signed [POS_W-1:0] MAX_FP = POS_W'(MAX_P << FP_SHIFT);

  logic signed [POS_W-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the conditional overrides, so no latch is inferred.
    cand = cur.dir ? (cur.pos - speed) : (cur.pos + speed);
    nxt  = '{pos: cand, dir: cur.dir};
    if (!cur.dir && (cand >= MAX_FP)) begin
      nxt = '{pos: MAX_FP, dir: 1'b1};
    end else if (cur.dir && (cand <= MIN_FP)) begin
      nxt = '{pos: MIN_FP, dir: 1'b0};
    end
  end

endmodule

// File: rtl/ground_scheduler.sv
// Time-multiplexed mover for NUM_GROUNDS vertical platforms: one ground per cycle
// through a single ground_step, once per unpaused frame.
module ground_scheduler
  import ground_pkg::*;
#(
  parameter int NUM_GROUNDS = 4,
  parameter int MIN_P       = 90,
  parameter int MAX_P       = 385,
  parameter int BASE_SPEED  = 30,
  parameter int X_BASE      = 120,
  parameter int X_STEP      = 100,
  parameter int Y_STEP      = 60
) (
  input logic               clk,
  input logic               resetN,
  ground_scheduler_if.slave bus
);

  localparam int                IDX_W = (NUM_GROUNDS > 1) ? $clog2(NUM_GROUNDS) : 1;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_GROUNDS - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [POS_W-1:0] speed_q, speed_d;
  logic                    overrun_q, overrun_d;
  ground_t                 grounds_q [NUM_GROUNDS];
  ground_t                 grounds_d [NUM_GROUNDS];
  ground_t                 step_out;

  function automatic ground_t init_ground(input int i);
    return '{pos: POS_W'((MIN_P + i * Y_STEP) << FP_SHIFT), dir: i[0]};
  endfunction

  ground_step #(
    .MIN_P (MIN_P),
    .MAX_P (MAX_P)
  ) u_step (
    .cur   (grounds_q[idx_q]),
    .speed (speed_q),
    .nxt   (step_out)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    speed_d   = speed_q;
    overrun_d = overrun_q;
    grounds_d = grounds_q;
    case (state_q)
      IDLE: begin
        if (bus.startOfFrame && !bus.pause) begin
          state_d = SWEEP;
          idx_d   = '0;
          speed_d = level_speed(BASE_SPEED, bus.level);
        end
      end
      SWEEP: begin
        if (bus.groundEnable[idx_q]) begin
          grounds_d[idx_q] = step_out;
        end
        if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A frame pulse that lands mid-sweep is dropped; remember that it happened.
    if (bus.startOfFrame && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      speed_q   <= '0;
      overrun_q <= 1'b0;
      // NOTE: the ground array is reset element by element because its start positions are architectural.
      for (int i = 0; i < NUM_GROUNDS; i++) begin
        grounds_q[i] <= init_ground(i);
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      speed_q   <= speed_d;
      overrun_q <= overrun_d;
      grounds_q <= grounds_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.frameDone = (state_q == DONE);
  assign bus.overrun   = overrun_q;

  for (genvar g = 0; g < NUM_GROUNDS; g++) begin : g_coord
    assign bus.topLeftX[g*COORD_W +: COORD_W] = COORD_W'(X_BASE + g * X_STEP);
    assign bus.topLeftY[g*COORD_W +: COORD_W] = grounds_q[g].pos[FP_SHIFT +: COORD_W];
  end

endmodule
